cla_2lvl_add16: RTL and testbench
=================================

// Module: cla_2lvl_add16
// PURPOSE
// - 16-bit unsigned adder with carry-in and carry-out, built as a two-level
//   carry-lookahead adder (CLA).
// - Level 1 is four 4-bit CLA groups. Level 2 is one lookahead unit that takes
//   the group propagate/generate (P/G) signals.
// - The sum and carry-out are captured in an output register (1-cycle latency).
// - Used as the fast-add leaf in the multiplier/adder datapaths.
// PARAMETERS
// - None. The width is fixed at 16 bits: 4 groups x 4 bits.
// PORTS
// - clk  input   1   rising-edge clock; single clock domain
// - rst  input   1   synchronous reset, active-high
// - A    input   16  operand A, unsigned
// - B    input   16  operand B, unsigned
// - ci   input   1   carry-in into bit 0
// - S    output  16  registered sum, {co,S} = A + B + ci
// - co   output  1   registered carry-out from bit 15
// BEHAVIOUR
// - Bit level:
//   - p[i] = A[i]^B[i]
//   - g[i] = A[i]&B[i]
// - Group k (bits 4k..4k+3), carries are lookahead, not rippled:
//   - c1 = g0 | p0&cin
//   - c2 = g1 | p1&g0 | p1&p0&cin
//   - c3 follows the same pattern.
//   - PG = p3&p2&p1&p0
//   - GG = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0
// - Level 2 computes the group carry-ins from PG/GG and ci:
//   - C4  = GG0 | PG0&ci
//   - C8  = GG1 | PG1&GG0 | PG1&PG0&ci
//   - C12 = the same expansion over groups 0..2
//   - C16 = the same expansion over groups 0..3; C16 = co_next
// - Sum: S_next[i] = p[i] ^ c[i], where c[0] = ci.
// - Register:
//   - On each rising clk edge: if rst, S <= 0 and co <= 0; otherwise
//     S <= S_next and co <= C16.
//   - Latency is exactly 1 cycle. A result is available every cycle
//     (throughput 1/cycle). There is no handshake and no enable.
// - Reset:
//   - Outputs are 0 from the first edge with rst=1.
//   - If rst is asserted mid-stream, the outputs show 0 on the next edge and the
//     in-flight result is discarded.
//   - The first valid result appears one edge after rst deasserts, using the
//     inputs sampled at that edge.
// - Arithmetic:
//   - Modulo 2^16 for S; the full result is 17 bits, {co,S}.
//   - No signed or overflow flag. Signed overflow is the caller's job
//     (co ^ c15).
// - Boundaries:
//   - FFFF+0001+0 -> S=0000, co=1.
//   - FFFF+FFFF+1 -> S=FFFF, co=1.
//   - 0000+0000+1 -> S=0001, co=0.
//   - Carry must cross all four group boundaries in the same cycle.
// - The combinational path is purely two-level lookahead. There is no ripple
//   between groups.
// TESTING
// - Reset: rst=1 with A=1234, B=1111, ci=1 -> after the edge S=0000, co=0.
//   Deassert rst -> next edge S=2346, co=0.
// - Sweep: ci in {0,1}, A=0..255, B=0..31, new vector every cycle -> each output
//   equals the 1-cycle-delayed {co,S} = A+B+ci, with zero mismatches.
// - Full carry chain: A=FFFF, B=0000, ci=1 -> S=0000, co=1.
//   A=FFFF, B=0001, ci=0 -> S=0000, co=1.
// - Group boundaries: A=000F, B=0001, ci=0 -> 0010.
//   A=00FF, B=0001 -> 0100.
//   A=0FFF, B=0001 -> 1000.
//   All with co=0.
// - Max: A=FFFF, B=FFFF, ci=1 -> S=FFFF, co=1.
//   A=8000, B=8000, ci=0 -> S=0000, co=1.
// - Random: 10k random A/B/ci against the 17-bit reference sum. Includes
//   mid-stream rst pulses, which must zero the outputs for exactly the pulsed
//   cycles.

Source files
------------

// File: rtl/cla_2lvl_add16.sv
// Two-level carry-lookahead 16-bit adder: {co,S} = A + B + ci, four 4-bit CLA groups plus one group lookahead unit.
// Latency: 1 cycle (sum and carry-out registered), throughput one result per cycle.
// Backpressure: none; no handshake or enable, a new operand pair is accepted every cycle.

// One 4-bit lookahead group: internal carries plus group propagate/generate.
module cla4_group (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] c,
  output logic       pg,
  output logic       gg
);

  // Every carry is a flat sum-of-products of cin, never a ripple of c[i-1].
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

module cla_2lvl_add16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        ci,
  output logic [15:0] S,
  output logic        co
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c_bit;
  logic [3:0]  grp_pg;
  logic [3:0]  grp_gg;
  logic [4:0]  grp_c;
  logic [15:0] s_next;

  assign p = A ^ B;
  assign g = A & B;

  // Level 1: four independent lookahead groups, each fed its carry-in from level 2.
  for (genvar k = 0; k < 4; k++) begin : g_grp
    cla4_group u_grp (
      .p   (p[4*k +: 4]),
      .g   (g[4*k +: 4]),
      .cin (grp_c[k]),
      .c   (c_bit[4*k +: 4]),
      .pg  (grp_pg[k]),
      .gg  (grp_gg[k])
    );
  end

  // Level 2: group carry-ins expanded directly from ci, so a carry crosses all groups in one pass.
  assign grp_c[0] = ci;
  assign grp_c[1] = grp_gg[0] | (grp_pg[0] & ci);
  assign grp_c[2] = grp_gg[1] | (grp_pg[1] & grp_gg[0]) | (grp_pg[1] & grp_pg[0] & ci);
  assign grp_c[3] = grp_gg[2] | (grp_pg[2] & grp_gg[1]) | (grp_pg[2] & grp_pg[1] & grp_gg[0])
                  | (grp_pg[2] & grp_pg[1] & grp_pg[0] & ci);
  assign grp_c[4] = grp_gg[3] | (grp_pg[3] & grp_gg[2]) | (grp_pg[3] & grp_pg[2] & grp_gg[1])
                  | (grp_pg[3] & grp_pg[2] & grp_pg[1] & grp_gg[0])
                  | (grp_pg[3] & grp_pg[2] & grp_pg[1] & grp_pg[0] & ci);

  assign s_next = p ^ c_bit;

  // Output register: reset discards any in-flight result, otherwise capture this cycle's sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      S  <= 16'h0000;
      co <= 1'b0;
    end else begin
      S  <= s_next;
      co <= grp_c[4];
    end
  end

endmodule

// File: tb/tb_cla_2lvl_add16.sv
module tb_cla_2lvl_add16;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        ci;
  logic [15:0] S;
  logic        co;

  int n_tests;
  int n_fail;

  cla_2lvl_add16 dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .ci  (ci),
    .S   (S),
    .co  (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 17-bit integer addition.
  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {16'h0000, c};
  endfunction

  // Advance past one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    rst = 1'b1; A = 16'h1234; B = 16'h1111; ci = 1'b1;
    tick();
    n_tests++;
    if ({co, S} !== 17'h0_0000) begin
      n_fail++;
      $display("FAIL reset_hold: got co=%b S=%h, expected co=0 S=0000", co, S);
    end
    rst = 1'b0;
    exp = 17'h0_2346;
    tick();
    n_tests++;
    if ({co, S} !== exp) begin
      n_fail++;
      $display("FAIL reset_release: got co=%b S=%h, expected co=%b S=%h", co, S, exp[16], exp[15:0]);
    end
  endtask

  task automatic test_latency();
    logic [16:0] exp_old;
    A = 16'h0100; B = 16'h0023; ci = 1'b0;
    exp_old = 17'h0_0123;
    tick();
    // New operands must not show up before the next edge.
    A = 16'hFFFF; B = 16'hFFFF; ci = 1'b1;
    #3;
    n_tests++;
    if ({co, S} !== exp_old) begin
      n_fail++;
      $display("FAIL latency_hold: got co=%b S=%h, expected co=%b S=%h", co, S, exp_old[16], exp_old[15:0]);
    end
    tick();
    n_tests++;
    if ({co, S} !== 17'h1_FFFF) begin
      n_fail++;
      $display("FAIL latency_update: got co=%b S=%h, expected co=1 S=ffff", co, S);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] ta [8];
    logic [15:0] tb [8];
    logic        tc [8];
    logic [16:0] te [8];
    ta = '{16'hFFFF, 16'hFFFF, 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'h8000, 16'h0000};
    tb = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'h8000, 16'h0000};
    tc = '{1'b1,     1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b1};
    te = '{17'h1_0000, 17'h1_0000, 17'h0_0010, 17'h0_0100, 17'h0_1000, 17'h1_FFFF, 17'h1_0000, 17'h0_0001};
    for (int i = 0; i < 8; i++) begin
      A = ta[i]; B = tb[i]; ci = tc[i];
      tick();
      n_tests++;
      if ({co, S} !== te[i]) begin
        n_fail++;
        $display("FAIL boundary_%0d (%h+%h+%b): got co=%b S=%h, expected co=%b S=%h",
                 i, ta[i], tb[i], tc[i], co, S, te[i][16], te[i][15:0]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [16:0] exp;
    int          sweep_fail;
    sweep_fail = 0;
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 256; a++) begin
        for (int b = 0; b < 32; b++) begin
          A = 16'(a); B = 16'(b); ci = 1'(c);
          exp = ref_sum(A, B, ci);
          tick();
          n_tests++;
          if ({co, S} !== exp) begin
            n_fail++;
            sweep_fail++;
            if (sweep_fail <= 10)
              $display("FAIL sweep (%h+%h+%0d): got co=%b S=%h, expected co=%b S=%h",
                       a, b, c, co, S, exp[16], exp[15:0]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [16:0] exp;
    int          rnd_fail;
    rnd_fail = 0;
    for (int i = 0; i < 10000; i++) begin
      A  = 16'($urandom);
      B  = 16'($urandom);
      ci = 1'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      exp = rst ? 17'h0_0000 : ref_sum(A, B, ci);
      tick();
      n_tests++;
      if ({co, S} !== exp) begin
        n_fail++;
        rnd_fail++;
        if (rnd_fail <= 10)
          $display("FAIL random_%0d (rst=%b %h+%h+%b): got co=%b S=%h, expected co=%b S=%h",
                   i, rst, A, B, ci, co, S, exp[16], exp[15:0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; A = 16'h0000; B = 16'h0000; ci = 1'b0;
    test_reset();
    test_latency();
    test_boundaries();
    test_sweep();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
